// File: rtl/axi_rcoal_pkg.sv
// Shared types and width helpers for the AXI read coalescer.
// Stats outputs are enabled with the AXI_RCOAL_STATS_EN macro in the top.
package axi_rcoal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL_AR,
    ST_FILL_R,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Widths for the default geometry (16 beats x 32 bits, 48-bit addresses)
  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 48;
  localparam int DEF_LB        = DEF_BURST_LEN * DEF_DATA_W / 8;
  localparam int DEF_OFF_W     = clogb2(DEF_DATA_W / 8);
  localparam int DEF_IDX_W     = clogb2(DEF_BURST_LEN);
  localparam int DEF_TAG_W     = DEF_ADDR_W - clogb2(DEF_LB);

endpackage

// File: rtl/axi_rcoal_line.sv
// One coalescer line: burst-sized data array, tag, valid bit and tag compare.
module axi_rcoal_line
  import axi_rcoal_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int TAG_W     = 42,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              set,
  input  logic              tag_ld,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  cmp_tag,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              hit,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [BURST_LEN];
  logic [TAG_W-1:0]  tag_q;
  logic              vld_q;

  // Clear wins over set so a flush on the final fill beat leaves the line invalid
  always_ff @(posedge clk) begin
    if (!rstn)       vld_q <= 1'b0;
    else if (clr)    vld_q <= 1'b0;
    else if (set)    vld_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tag_ld) tag_q <= tag_in;
    if (wr_en)  mem[wr_idx] <= wr_data;
  end

  assign hit     = vld_q && (tag_q == cmp_tag);
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axi_read_coalescer.sv
// Multi-line, fully associative read coalescer with round-robin replacement.
// Define AXI_RCOAL_STATS_EN to add the hit_count/miss_count outputs.
module axi_read_coalescer
  import axi_rcoal_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 48,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_LINES        = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_M_AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [C_M_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
`ifdef AXI_RCOAL_STATS_EN
  ,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
`endif
);

  localparam int OFF_W = clogb2(C_M_AXI_DATA_WIDTH / 8);
  localparam int IDX_W = clogb2(C_M_AXI_BURST_LEN);
  localparam int LB_W  = OFF_W + IDX_W;
  localparam int TAG_W = C_M_AXI_ADDR_WIDTH - LB_W;
  localparam int LN_W  = (C_NUM_LINES > 1) ? clogb2(C_NUM_LINES) : 1;
  localparam int DW    = C_M_AXI_DATA_WIDTH;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_e state, state_n;

  logic [TAG_W-1:0]            tag_q;
  logic [IDX_W-1:0]            idx_q;
  logic [C_M_AXI_ID_WIDTH-1:0] id_q;
  logic [LN_W-1:0]             rr_q;
  logic [IDX_W-1:0]            beat_q;
  logic [1:0]                  sticky_q;
  logic                        flushed_q;
  logic [DW-1:0]               rdata_q;
  logic [1:0]                  rresp_q;

  logic [C_NUM_LINES-1:0] hit_vec;
  logic [DW-1:0]          line_rdata [C_NUM_LINES];
  logic [DW-1:0]          hit_data;
  logic                   lookup_hit, miss, ar_hs, beat_hs, last_hs, early, fill_ok;
  logic [1:0]             beat_resp, fill_resp;
  logic                   unused_addr_lsb;

  assign ar_hs      = s_axi_arvalid && s_axi_arready;
  assign lookup_hit = |hit_vec;
  assign miss       = (state == ST_LOOKUP) && !lookup_hit;
  assign beat_hs    = (state == ST_FILL_R) && m_axi_rvalid;
  assign last_hs    = beat_hs && m_axi_rlast;
  assign early      = beat_q != IDX_W'(C_M_AXI_BURST_LEN - 1);
  assign beat_resp  = resp_max(sticky_q, m_axi_rresp);
  assign fill_resp  = early ? RESP_SLVERR : beat_resp;
  // A flush seen anywhere during the fill, including this beat, blocks validation
  assign fill_ok    = last_hs && (fill_resp == RESP_OKAY) && !flushed_q && !flush;

  assign unused_addr_lsb = ^s_axi_araddr[OFF_W-1:0];

  for (genvar i = 0; i < C_NUM_LINES; i++) begin : gen_line
    logic sel;
    assign sel = (rr_q == LN_W'(i));
    axi_rcoal_line #(
      .DATA_W    (DW),
      .BURST_LEN (C_M_AXI_BURST_LEN),
      .TAG_W     (TAG_W),
      .IDX_W     (IDX_W)
    ) u_line (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (flush || (miss && sel)),
      .set     (fill_ok && sel),
      .tag_ld  (miss && sel),
      .tag_in  (tag_q),
      .wr_en   (beat_hs && sel),
      .wr_idx  (beat_q),
      .wr_data (m_axi_rdata),
      .cmp_tag (tag_q),
      .rd_idx  (idx_q),
      .hit     (hit_vec[i]),
      .rd_data (line_rdata[i])
    );
  end

  // A tag is never resident twice, so an OR across hitting lines is a clean mux
  always_comb begin
    hit_data = '0;
    for (int i = 0; i < C_NUM_LINES; i++) begin
      if (hit_vec[i]) hit_data = hit_data | line_rdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    s_axi_arready = 1'b0;
    m_axi_arvalid = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (state)
      ST_IDLE: begin
        s_axi_arready = rstn;
        if (s_axi_arvalid && rstn) state_n = ST_LOOKUP;
      end
      ST_LOOKUP:  state_n = lookup_hit ? ST_RESP : ST_FILL_AR;
      ST_FILL_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_n = ST_FILL_R;
      end
      ST_FILL_R:  if (last_hs) state_n = ST_RESP;
      ST_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_n = ST_IDLE;
      end
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_q      <= '0;
      flushed_q <= 1'b0;
    end else begin
      if (miss)       flushed_q <= flush;
      else if (flush) flushed_q <= 1'b1;
      if (last_hs) rr_q <= (rr_q == LN_W'(C_NUM_LINES - 1)) ? '0 : rr_q + LN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      tag_q <= s_axi_araddr[C_M_AXI_ADDR_WIDTH-1:LB_W];
      idx_q <= s_axi_araddr[LB_W-1:OFF_W];
      id_q  <= s_axi_arid;
    end
    if (miss) begin
      beat_q   <= '0;
      sticky_q <= RESP_OKAY;
    end else if (beat_hs) begin
      beat_q   <= beat_q + IDX_W'(1);
      sticky_q <= beat_resp;
    end
    if ((state == ST_LOOKUP) && lookup_hit) begin
      rdata_q <= hit_data;
      rresp_q <= RESP_OKAY;
    end
    if (beat_hs && (beat_q == idx_q)) rdata_q <= m_axi_rdata;
    if (last_hs) rresp_q <= fill_resp;
  end

`ifdef AXI_RCOAL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == ST_LOOKUP) begin
      if (lookup_hit) hit_count  <= hit_count + 32'd1;
      else            miss_count <= miss_count + 32'd1;
    end
  end
`endif

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = {tag_q, {LB_W{1'b0}}};
  assign m_axi_arlen   = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi_arsize  = 3'(OFF_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_rready  = 1'b1;

  assign s_axi_rid   = id_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_rlast = s_axi_rvalid;

endmodule

// File: tb/tb_axi_read_coalescer.sv
// Bench for axi_read_coalescer: directed steps plus random reads against a line-level model.
module tb_axi_read_coalescer;

  localparam int BL = 16;
  localparam int NL = 4;
  localparam int LB = 64;

  logic        clk, rstn, flush;
  logic [0:0]  m_axi_arid;
  logic [47:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [0:0]  s_axi_arid;
  logic [47:0] s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [0:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
`ifdef AXI_RCOAL_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  axi_read_coalescer dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
`ifdef AXI_RCOAL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // Memory behind the master port: word value depends on address and a per-fill salt
  function automatic logic [31:0] pat(input logic [47:0] a, input logic [31:0] salt);
    return (a[31:0] * 32'h9E37_79B1) ^ salt ^ {16'h0, a[47:32]};
  endfunction

  // Slave-side configuration and observations
  int          n_fills = 0;
  int          err_beat = -1;
  logic [1:0]  err_val = 2'b10;
  int          beats_to_send = BL;
  logic [47:0] fill_addr;
  logic [7:0]  fill_len;
  logic [2:0]  fill_size;
  logic [1:0]  fill_burst;
  logic [11:0] fill_misc;
  logic [31:0] fill_salt;
  int          ar_cyc, rlast_cyc;

  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rresp   = 2'b00;
    m_axi_rdata   = '0;
    forever begin
      @(negedge clk);
      if (m_axi_arvalid === 1'b1) begin
        ar_cyc     = cyc;
        fill_addr  = m_axi_araddr;
        fill_len   = m_axi_arlen;
        fill_size  = m_axi_arsize;
        fill_burst = m_axi_arburst;
        fill_misc  = {m_axi_arid, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos[2:0]};
        fill_salt  = $urandom();
        n_fills++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        for (int b = 0; b < beats_to_send; b++) begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          repeat ($urandom_range(0, 1)) @(negedge clk);
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = pat(fill_addr + 48'(b * 4), fill_salt);
          m_axi_rresp  = (b == err_beat) ? err_val : 2'b00;
          m_axi_rlast  = (b == beats_to_send - 1);
          if (b == beats_to_send - 1) rlast_cyc = cyc;
          @(negedge clk);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
    end
  end

  // Line-level reference: resident line numbers, valid flags, fill salts, replacement pointer
  longint      m_tag  [NL];
  bit          m_vld  [NL];
  logic [31:0] m_salt [NL];
  int          m_ptr = 0;
  int          m_hits = 0, m_misses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [47:0] addr, input logic [0:0] id, input int flush_at,
                         input int hold, output bit was_fill, output logic [1:0] resp_o);
    longint      line;
    logic [47:0] waddr;
    int          hit_i, fills0, hs_cyc, rv_cyc, c, n;
    bit          got, fired, stable;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    logic [34:0] snap;
    line   = longint'(addr) / LB;
    waddr  = addr & ~48'h3;
    hit_i  = -1;
    for (int i = 0; i < NL; i++) if (m_vld[i] && m_tag[i] == line) hit_i = i;
    fills0 = n_fills;
    fired  = 1'b0;

    @(negedge clk);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    s_axi_arid    = id;
    for (n = 0; n < 50 && s_axi_arready !== 1'b1; n++) @(negedge clk);
    chk("ar_accept", s_axi_arready, 1'b1);
    hs_cyc = cyc;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = {$urandom(), $urandom()};
    got = 1'b0;
    for (c = 1; c < 300; c++) begin
      if (s_axi_rvalid === 1'b1) begin
        got   = 1'b1;
        flush = 1'b0;
        break;
      end
      flush = (c == flush_at);
      if (c == flush_at) fired = 1'b1;
      @(negedge clk);
    end
    flush  = 1'b0;
    rv_cyc = cyc;
    chk("rvalid_seen", got, 1'b1);
    was_fill = (n_fills != fills0);
    resp_o   = s_axi_rresp;
    chk("fill_vs_model", was_fill, hit_i < 0);
    chk("rid", s_axi_rid, id);
    chk("rlast", s_axi_rlast, s_axi_rvalid);

    if (hit_i >= 0) begin
      m_hits++;
      chk("hit_latency", rv_cyc - hs_cyc, 2);
      chk("hit_rresp", s_axi_rresp, 2'b00);
      chk("hit_rdata", s_axi_rdata, pat(waddr, m_salt[hit_i]));
    end else begin
      m_misses++;
      if (beats_to_send < BL)  exp_resp = 2'b10;
      else if (err_beat >= 0)  exp_resp = err_val;
      else                     exp_resp = 2'b00;
      exp_data = pat(waddr, fill_salt);
      chk("fill_araddr", fill_addr, 48'(line * LB));
      chk("miss_ar_latency", ar_cyc - hs_cyc, 2);
      chk("rlast_to_rvalid", rv_cyc - rlast_cyc, 1);
      chk("miss_rresp", s_axi_rresp, exp_resp);
      if (beats_to_send == BL) chk("miss_rdata", s_axi_rdata, exp_data);
      m_vld[m_ptr] = 1'b0;
      if (exp_resp == 2'b00 && !fired) begin
        m_vld[m_ptr]  = 1'b1;
        m_tag[m_ptr]  = line;
        m_salt[m_ptr] = fill_salt;
      end
      m_ptr = (m_ptr + 1) % NL;
    end
    if (fired) for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;

    snap   = {s_axi_rdata, s_axi_rid, s_axi_rresp};
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (s_axi_rvalid !== 1'b1 || s_axi_arready !== 1'b0 ||
          {s_axi_rdata, s_axi_rid, s_axi_rresp} !== snap) stable = 1'b0;
    end
    if (hold > 0) chk("resp_held_stable", stable, 1'b1);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("resp_accepted", s_axi_rvalid, 1'b0);
    chk("arready_after_resp", s_axi_arready, 1'b1);
  endtask

  initial begin
    bit         f;
    logic [1:0] r;
    logic [47:0] a;
    int         fa;
    rstn          = 1'b0;
    flush         = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arid    = '0;
    s_axi_rready  = 1'b0;
    for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_arready", s_axi_arready, 1'b0);
    chk("rst_m_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_s_rvalid", s_axi_rvalid, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", s_axi_arready, 1'b1);
    chk("m_rready_const", m_axi_rready, 1'b1);

    // Cold read: fill of line 0x1000, beat-1 word returned
    do_read(48'h1004, 1'b1, 0, 0, f, r);
    chk("cold_fill", f, 1'b1);
    chk("arlen", fill_len, 8'd15);
    chk("arsize", fill_size, 3'd2);
    chk("arburst", fill_burst, 2'b01);
    chk("ar_misc", fill_misc, 12'b0_0_0010_000_000);
    chk("cold_word", s_axi_rdata, pat(48'h1004, fill_salt));

    do_read(48'h1000, 1'b0, 0, 0, f, r);
    chk("hit_1000", f, 1'b0);
    do_read(48'h103C, 1'b1, 0, 0, f, r);
    chk("hit_103c", f, 1'b0);

    // Five distinct lines evict the oldest
    do_read(48'h0000, 1'b0, 0, 0, f, r);
    do_read(48'h0040, 1'b0, 0, 0, f, r);
    do_read(48'h0080, 1'b0, 0, 0, f, r);
    do_read(48'h00C0, 1'b0, 0, 0, f, r);
    do_read(48'h0100, 1'b0, 0, 0, f, r);
    do_read(48'h0000, 1'b0, 0, 0, f, r);
    chk("evicted_refill", f, 1'b1);

    // Beat 3 SLVERR: error returned and line not kept
    err_beat = 3;
    err_val  = 2'b10;
    do_read(48'h2008, 1'b1, 0, 0, f, r);
    chk("err_resp", r, 2'b10);
    err_beat = -1;
    do_read(48'h2008, 1'b1, 0, 0, f, r);
    chk("err_refill", f, 1'b1);

    // Flush during a fill
    do_read(48'h3000, 1'b0, 4, 0, f, r);
    chk("flush_fill_resp", r, 2'b00);
    do_read(48'h3000, 1'b0, 0, 0, f, r);
    chk("flush_refill", f, 1'b1);

    // Flush coincident with a LOOKUP hit
    do_read(48'h3004, 1'b1, 1, 0, f, r);
    chk("flush_lookup_hit", f, 1'b0);
    do_read(48'h3004, 1'b1, 0, 0, f, r);
    chk("flush_lookup_after", f, 1'b1);

    // Response back-pressure on a hit and on a miss
    do_read(48'h3008, 1'b1, 0, 10, f, r);
    chk("hold_hit", f, 1'b0);
    do_read(48'h5010, 1'b0, 0, 10, f, r);
    chk("hold_miss", f, 1'b1);

    // Early rlast
    beats_to_send = 5;
    do_read(48'h4000, 1'b1, 0, 0, f, r);
    chk("early_resp", r, 2'b10);
    beats_to_send = BL;
    do_read(48'h4000, 1'b1, 0, 0, f, r);
    chk("early_refill", f, 1'b1);

    // Random traffic over eight lines
    for (int k = 0; k < 60; k++) begin
      a  = 48'($urandom_range(0, 7) * LB + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      fa = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
      err_beat      = ($urandom_range(0, 9) == 0) ? $urandom_range(0, BL - 1) : -1;
      err_val       = 2'($urandom_range(1, 3));
      beats_to_send = ($urandom_range(0, 19) == 0) ? $urandom_range(1, BL - 1) : BL;
      do_read(a, 1'($urandom_range(0, 1)), fa, $urandom_range(0, 3), f, r);
    end
    err_beat      = -1;
    beats_to_send = BL;

`ifdef AXI_RCOAL_STATS_EN
    chk("hit_count", hit_count, 32'(m_hits));
    chk("miss_count", miss_count, 32'(m_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
